// File: rtl/softmc_riffa_bridge.sv
// -----------------------------------------------------------------------------
// softmc_riffa_bridge
//
// Bridges one RIFFA channel to the SoftMC instruction and readback interfaces.
//   RX path : PCIe words of C_PCI_DATA_WIDTH bits are held one at a time and
//             issued to the MC as 32-bit instructions, lowest slice first.
//   TX path : DRAM readback words (DQ_WIDTH*4 bits) are popped from a
//             first-word-fall-through FIFO into a one-word stage, sliced into
//             PCIe beats (lowest slice first) and grouped into transactions of
//             CHUNKS_PER_TXN words. An open transaction that starves for
//             IDLE_TIMEOUT cycles is closed early and counted.
//
// Ports
//   clk, rst                 sole clock, asynchronous active-high reset
//   CHNL_RX_CLK/CHNL_TX_CLK  clk forwarded to RIFFA
//   CHNL_RX*                 RIFFA RX request/ack and data stream
//   CHNL_TX*                 RIFFA TX request, fixed length/offset, data stream
//   app_en/app_ack/app_instr instruction stream towards the MC
//   process_iseq             MC started executing; re-arms the RX acknowledge
//   rdback_fifo_*/rdback_data readback FIFO (FWFT) from the MC
//   tx_timeout_cnt           saturating count of timeout-closed transactions
// -----------------------------------------------------------------------------
module softmc_riffa_bridge #(
   parameter int C_PCI_DATA_WIDTH = 64,
   parameter int DQ_WIDTH         = 64,
   parameter int CHUNKS_PER_TXN   = 256,
   parameter int IDLE_TIMEOUT     = 128
) (
   input  logic                          clk,
   input  logic                          rst,

   output logic                          CHNL_RX_CLK,
   input  logic                          CHNL_RX,
   output logic                          CHNL_RX_ACK,
   input  logic                          CHNL_RX_LAST,
   input  logic [31:0]                   CHNL_RX_LEN,
   input  logic [30:0]                   CHNL_RX_OFF,
   input  logic [C_PCI_DATA_WIDTH-1:0]   CHNL_RX_DATA,
   input  logic                          CHNL_RX_DATA_VALID,
   output logic                          CHNL_RX_DATA_REN,

   output logic                          CHNL_TX_CLK,
   output logic                          CHNL_TX,
   input  logic                          CHNL_TX_ACK,
   output logic                          CHNL_TX_LAST,
   output logic [31:0]                   CHNL_TX_LEN,
   output logic [30:0]                   CHNL_TX_OFF,
   output logic [C_PCI_DATA_WIDTH-1:0]   CHNL_TX_DATA,
   output logic                          CHNL_TX_DATA_VALID,
   input  logic                          CHNL_TX_DATA_REN,

   output logic                          app_en,
   input  logic                          app_ack,
   output logic [31:0]                   app_instr,

   input  logic                          process_iseq,

   input  logic                          rdback_fifo_empty,
   output logic                          rdback_fifo_rden,
   input  logic [DQ_WIDTH*4-1:0]         rdback_data,

   output logic [15:0]                   tx_timeout_cnt
);

   localparam int IPW      = C_PCI_DATA_WIDTH / 32;
   localparam int RD_WIDTH = DQ_WIDTH * 4;
   localparam int BEATS    = RD_WIDTH / C_PCI_DATA_WIDTH;
   localparam int IDX_W    = (IPW > 1) ? $clog2(IPW) : 1;
   localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CHUNK_W  = (CHUNKS_PER_TXN > 1) ? $clog2(CHUNKS_PER_TXN) : 1;
   localparam int IDLE_W   = $clog2(IDLE_TIMEOUT);

   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(IPW - 1);
   localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
   localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BEATS - 1);
   localparam logic [BEAT_W-1:0]  BEAT_ONE   = BEAT_W'(1);
   localparam logic [CHUNK_W-1:0] CHUNK_LAST = CHUNK_W'(CHUNKS_PER_TXN - 1);
   localparam logic [CHUNK_W-1:0] CHUNK_ONE  = CHUNK_W'(1);
   localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
   localparam logic [IDLE_W-1:0]  IDLE_ONE   = IDLE_W'(1);
   localparam logic [31:0]        TX_LEN     = 32'(CHUNKS_PER_TXN * DQ_WIDTH * 4 / 32);

   localparam logic [0:0] RX_WAIT_REQ = 1'b0;
   localparam logic [0:0] RX_ACKED    = 1'b1;
   localparam logic [0:0] TX_IDLE     = 1'b0;
   localparam logic [0:0] TX_ACTIVE   = 1'b1;

   // RX request handshake
   logic [0:0]                  rx_state_r;
   logic                        rx_ack_r;

   // RX unpacker
   logic [C_PCI_DATA_WIDTH-1:0] hold_data_r;
   logic                        hold_valid_r;
   logic [IDX_W-1:0]            idx_r;
   logic                        rx_ren_s;
   logic [31:0]                 app_instr_s;

   // Readback stage and TX sequencing
   logic [RD_WIDTH-1:0]         rd_data_r;
   logic                        rd_valid_r;
   logic                        rd_pop_s;
   logic                        consume_s;
   logic                        tx_xfer_s;
   logic [0:0]                  tx_state_r;
   logic [BEAT_W-1:0]           beat_r;
   logic [CHUNK_W-1:0]          chunk_r;
   logic [IDLE_W-1:0]           idle_cnt_r;
   logic [15:0]                 tx_timeout_cnt_r;
   logic [C_PCI_DATA_WIDTH-1:0] tx_data_s;

   // Inputs RIFFA provides that this bridge has no use for.
   logic                        unused_s;
   assign unused_s = ^{CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_TX_ACK};

   // ---------------------------------------------------------------- RX ack
   // One ACK per instruction sequence; re-armed only once the MC starts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_r <= RX_WAIT_REQ;
         rx_ack_r   <= 1'b0;
      end else begin
         rx_ack_r <= 1'b0;
         case (rx_state_r)
            RX_WAIT_REQ: begin
               if (CHNL_RX) begin
                  rx_ack_r   <= 1'b1;
                  rx_state_r <= RX_ACKED;
               end
            end
            RX_ACKED: begin
               if (process_iseq) begin
                  rx_state_r <= RX_WAIT_REQ;
               end
            end
            default: rx_state_r <= RX_WAIT_REQ;
         endcase
      end
   end

   // ---------------------------------------------------------- RX unpacker
   // A new word is fetched when the holder is empty or its last slice is
   // being taken this cycle, which keeps the instruction stream bubble-free.
   assign rx_ren_s = ~hold_valid_r | (app_ack & (idx_r == IDX_LAST));

   // Holding register: load on read-enable, otherwise step through the slices.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid_r <= 1'b0;
         hold_data_r  <= {C_PCI_DATA_WIDTH{1'b0}};
         idx_r        <= {IDX_W{1'b0}};
      end else if (rx_ren_s) begin
         hold_valid_r <= CHNL_RX_DATA_VALID;
         hold_data_r  <= CHNL_RX_DATA;
         idx_r        <= {IDX_W{1'b0}};
      end else if (app_ack) begin
         idx_r <= idx_r + IDX_ONE;
      end
   end

   // Select the 32-bit slice addressed by idx_r.
   always_comb begin
      app_instr_s = 32'h0000_0000;
      for (int i = 0; i < IPW; i++) begin
         app_instr_s = (idx_r == IDX_W'(i)) ? hold_data_r[i*32 +: 32] : app_instr_s;
      end
   end

   // -------------------------------------------------------- readback stage
   // A word is consumed when its last beat is accepted by RIFFA.
   assign tx_xfer_s = (tx_state_r == TX_ACTIVE) & rd_valid_r & CHNL_TX_DATA_REN;
   assign consume_s = tx_xfer_s & (beat_r == BEAT_LAST);
   // Refill in the same cycle as a consume so consecutive words abut.
   assign rd_pop_s  = ~rst & ~rdback_fifo_empty & (~rd_valid_r | consume_s);

   // One-word readback register fed from the FWFT FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_r <= 1'b0;
         rd_data_r  <= {RD_WIDTH{1'b0}};
      end else if (rd_pop_s) begin
         rd_valid_r <= 1'b1;
         rd_data_r  <= rdback_data;
      end else if (consume_s) begin
         rd_valid_r <= 1'b0;
      end
   end

   // ---------------------------------------------------------------- TX FSM
   // Transaction framing, beat/chunk sequencing and starvation timeout.
   // Starting requires REN low because RIFFA may leave REN asserted after
   // the previous transaction ended.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_r       <= TX_IDLE;
         beat_r           <= {BEAT_W{1'b0}};
         chunk_r          <= {CHUNK_W{1'b0}};
         idle_cnt_r       <= {IDLE_W{1'b0}};
         tx_timeout_cnt_r <= 16'h0000;
      end else begin
         case (tx_state_r)
            TX_IDLE: begin
               if (rd_valid_r & ~CHNL_TX_DATA_REN) begin
                  tx_state_r <= TX_ACTIVE;
                  beat_r     <= {BEAT_W{1'b0}};
                  chunk_r    <= {CHUNK_W{1'b0}};
                  idle_cnt_r <= {IDLE_W{1'b0}};
               end
            end
            TX_ACTIVE: begin
               if (tx_xfer_s) begin
                  idle_cnt_r <= {IDLE_W{1'b0}};
                  if (beat_r == BEAT_LAST) begin
                     beat_r <= {BEAT_W{1'b0}};
                     if (chunk_r == CHUNK_LAST) begin
                        chunk_r    <= {CHUNK_W{1'b0}};
                        tx_state_r <= TX_IDLE;
                     end else begin
                        chunk_r <= chunk_r + CHUNK_ONE;
                     end
                  end else begin
                     beat_r <= beat_r + BEAT_ONE;
                  end
               end else if (~rd_valid_r) begin
                  // rd_valid only drops at a word boundary, so closing here
                  // never truncates a readback word.
                  if (idle_cnt_r == IDLE_LAST) begin
                     idle_cnt_r <= {IDLE_W{1'b0}};
                     tx_state_r <= TX_IDLE;
                     if (tx_timeout_cnt_r != 16'hFFFF) begin
                        tx_timeout_cnt_r <= tx_timeout_cnt_r + 16'h0001;
                     end
                  end else begin
                     idle_cnt_r <= idle_cnt_r + IDLE_ONE;
                  end
               end
            end
            default: tx_state_r <= TX_IDLE;
         endcase
      end
   end

   // Select the PCIe beat addressed by beat_r from the readback word.
   always_comb begin
      tx_data_s = {C_PCI_DATA_WIDTH{1'b0}};
      for (int i = 0; i < BEATS; i++) begin
         tx_data_s = (beat_r == BEAT_W'(i)) ? rd_data_r[i*C_PCI_DATA_WIDTH +: C_PCI_DATA_WIDTH]
                                            : tx_data_s;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign CHNL_RX_CLK        = clk;
   assign CHNL_TX_CLK        = clk;
   assign CHNL_RX_ACK        = rx_ack_r;
   assign CHNL_RX_DATA_REN   = rx_ren_s;
   assign app_en             = hold_valid_r;
   assign app_instr          = app_instr_s;
   assign rdback_fifo_rden   = rd_pop_s;
   assign CHNL_TX            = (tx_state_r == TX_ACTIVE);
   assign CHNL_TX_DATA_VALID = (tx_state_r == TX_ACTIVE) & rd_valid_r;
   assign CHNL_TX_DATA       = tx_data_s;
   assign CHNL_TX_LAST       = 1'b1;
   assign CHNL_TX_LEN        = TX_LEN;
   assign CHNL_TX_OFF        = 31'h0000_0000;
   assign tx_timeout_cnt     = tx_timeout_cnt_r;

endmodule

// File: tb/tb_softmc_riffa_bridge.sv
// -----------------------------------------------------------------------------
// tb_softmc_riffa_bridge
//
// Directed sequence with randomized data/handshakes for softmc_riffa_bridge at
// default parameters. The bench keeps its own reference: an instruction queue
// for the RX path and a beat queue for the TX path, both filled from the words
// the bench sends, plus a queue-backed readback FIFO.
// -----------------------------------------------------------------------------
module tb_softmc_riffa_bridge;

   localparam int PW = 64;
   localparam int RW = 256;
   localparam int NB = RW / PW;

   logic          clk = 1'b0;
   logic          rst;
   logic          CHNL_RX_CLK, CHNL_TX_CLK;
   logic          CHNL_RX, CHNL_RX_ACK, CHNL_RX_LAST;
   logic [31:0]   CHNL_RX_LEN;
   logic [30:0]   CHNL_RX_OFF;
   logic [PW-1:0] CHNL_RX_DATA;
   logic          CHNL_RX_DATA_VALID, CHNL_RX_DATA_REN;
   logic          CHNL_TX, CHNL_TX_ACK, CHNL_TX_LAST;
   logic [31:0]   CHNL_TX_LEN;
   logic [30:0]   CHNL_TX_OFF;
   logic [PW-1:0] CHNL_TX_DATA;
   logic          CHNL_TX_DATA_VALID, CHNL_TX_DATA_REN;
   logic          app_en, app_ack;
   logic [31:0]   app_instr;
   logic          process_iseq;
   logic          rdback_fifo_empty, rdback_fifo_rden;
   logic [RW-1:0] rdback_data;
   logic [15:0]   tx_timeout_cnt;

   logic [RW-1:0] fifo_mem [0:1023];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   int            checks = 0;
   int            failures = 0;
   logic [PW-1:0] exp_beats [$];
   logic [31:0]   exp_instr [$];

   softmc_riffa_bridge dut (
      .clk(clk), .rst(rst),
      .CHNL_RX_CLK(CHNL_RX_CLK), .CHNL_RX(CHNL_RX), .CHNL_RX_ACK(CHNL_RX_ACK),
      .CHNL_RX_LAST(CHNL_RX_LAST), .CHNL_RX_LEN(CHNL_RX_LEN), .CHNL_RX_OFF(CHNL_RX_OFF),
      .CHNL_RX_DATA(CHNL_RX_DATA), .CHNL_RX_DATA_VALID(CHNL_RX_DATA_VALID),
      .CHNL_RX_DATA_REN(CHNL_RX_DATA_REN),
      .CHNL_TX_CLK(CHNL_TX_CLK), .CHNL_TX(CHNL_TX), .CHNL_TX_ACK(CHNL_TX_ACK),
      .CHNL_TX_LAST(CHNL_TX_LAST), .CHNL_TX_LEN(CHNL_TX_LEN), .CHNL_TX_OFF(CHNL_TX_OFF),
      .CHNL_TX_DATA(CHNL_TX_DATA), .CHNL_TX_DATA_VALID(CHNL_TX_DATA_VALID),
      .CHNL_TX_DATA_REN(CHNL_TX_DATA_REN),
      .app_en(app_en), .app_ack(app_ack), .app_instr(app_instr),
      .process_iseq(process_iseq),
      .rdback_fifo_empty(rdback_fifo_empty), .rdback_fifo_rden(rdback_fifo_rden),
      .rdback_data(rdback_data), .tx_timeout_cnt(tx_timeout_cnt)
   );

   initial forever #5 clk = ~clk;

   // FWFT readback FIFO: head word always visible, advanced on rden.
   assign rdback_fifo_empty = (rd_ptr == wr_ptr);
   assign rdback_data       = fifo_mem[rd_ptr % 1024];
   always @(posedge clk) begin
      if (rdback_fifo_rden) rd_ptr <= rd_ptr + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [RW-1:0] rand_word();
      logic [RW-1:0] w = {RW{1'b0}};
      for (int i = 0; i < RW / 32; i++) w = {w[RW-33:0], $urandom()};
      return w;
   endfunction

   // Queue a readback word; its beats leave lowest 64 bits first.
   task automatic push_word(input logic [RW-1:0] w);
      logic [RW-1:0] t = w;
      fifo_mem[wr_ptr % 1024] = w;
      wr_ptr++;
      for (int b = 0; b < NB; b++) begin
         exp_beats.push_back(t[PW-1:0]);
         t = t >> PW;
      end
   endtask

   // Drive REN (random or high) and score every accepted beat until the
   // expected beat queue is empty or the budget runs out.
   task automatic run_tx(input int budget, input bit rand_ren);
      int n = 0;
      while (exp_beats.size() > 0 && n < budget) begin
         @(negedge clk);
         CHNL_TX_DATA_REN = rand_ren ? ($urandom_range(0, 3) != 0) : 1'b1;
         #1;
         if (CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN) begin
            chk("tx_in_txn", CHNL_TX, 1'b1);
            chk("tx_data", CHNL_TX_DATA, exp_beats.pop_front());
         end
         n++;
      end
      chk("tx_all_beats", exp_beats.size(), 0);
   endtask

   // Count cycles CHNL_TX stays high after the last beat.
   task automatic wait_drop(output int n);
      n = 0;
      while (n < 400) begin
         @(negedge clk);
         #1;
         if (!CHNL_TX) break;
         n++;
      end
   endtask

   initial begin
      int            acks;
      int            n;
      logic [PW-1:0] w2;

      rst = 1'b1;
      CHNL_RX = 1'b0; CHNL_RX_LAST = 1'b0; CHNL_RX_LEN = 32'h0; CHNL_RX_OFF = 31'h0;
      CHNL_RX_DATA = {PW{1'b0}}; CHNL_RX_DATA_VALID = 1'b0;
      CHNL_TX_ACK = 1'b0; CHNL_TX_DATA_REN = 1'b0;
      app_ack = 1'b0; process_iseq = 1'b0;

      // ---- reset state, with a word waiting in the FIFO
      @(negedge clk);
      fifo_mem[wr_ptr % 1024] = rand_word();
      wr_ptr++;
      @(negedge clk); #1;
      chk("rst_rx_ack", CHNL_RX_ACK, 1'b0);
      chk("rst_tx", CHNL_TX, 1'b0);
      chk("rst_tx_valid", CHNL_TX_DATA_VALID, 1'b0);
      chk("rst_app_en", app_en, 1'b0);
      chk("rst_rden", rdback_fifo_rden, 1'b0);
      chk("rst_timeout_cnt", tx_timeout_cnt, 16'h0);
      chk("tx_len", CHNL_TX_LEN, 32'd2048);
      chk("tx_off", CHNL_TX_OFF, 31'h0);
      chk("tx_last", CHNL_TX_LAST, 1'b1);
      chk("rx_clk_fwd", CHNL_RX_CLK, clk);
      chk("tx_clk_fwd", CHNL_TX_CLK, clk);
      wr_ptr = rd_ptr;
      @(negedge clk);
      rst = 1'b0;

      // ---- RX unpack, two words back to back with app_ack held high
      w2 = {$urandom(), $urandom()};
      @(negedge clk);
      CHNL_RX_DATA = 64'h2222_2222_1111_1111; CHNL_RX_DATA_VALID = 1'b1; app_ack = 1'b1;
      #1 chk("rx_ren_empty", CHNL_RX_DATA_REN, 1'b1);
      @(negedge clk);
      CHNL_RX_DATA = w2;
      #1;
      chk("rx_app_en_n1", app_en, 1'b1);
      chk("rx_instr0", app_instr, 32'h1111_1111);
      chk("rx_ren_first", CHNL_RX_DATA_REN, 1'b0);
      @(negedge clk); #1;
      chk("rx_instr1", app_instr, 32'h2222_2222);
      chk("rx_ren_last", CHNL_RX_DATA_REN, 1'b1);
      @(negedge clk);
      CHNL_RX_DATA_VALID = 1'b0;
      #1;
      chk("rx_nobubble", app_en, 1'b1);
      chk("rx_instr2", app_instr, w2[31:0]);
      @(negedge clk); #1;
      chk("rx_instr3", app_instr, w2[63:32]);
      @(negedge clk); #1;
      chk("rx_drained", app_en, 1'b0);

      // ---- RX unpack, random words and random app_ack
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         CHNL_RX_DATA_VALID = ($urandom_range(0, 2) != 0);
         CHNL_RX_DATA = {$urandom(), $urandom()};
         app_ack = ($urandom_range(0, 3) != 0);
         #1;
         if (app_en && app_ack) begin
            if (exp_instr.size() == 0) chk("rx_spurious", app_en, 1'b0);
            else chk("rx_rand_instr", app_instr, exp_instr.pop_front());
         end
         if (CHNL_RX_DATA_REN && CHNL_RX_DATA_VALID) begin
            exp_instr.push_back(CHNL_RX_DATA[31:0]);
            exp_instr.push_back(CHNL_RX_DATA[63:32]);
         end
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         CHNL_RX_DATA_VALID = 1'b0; app_ack = 1'b1;
         #1;
         if (app_en) begin
            if (exp_instr.size() == 0) chk("rx_spurious", app_en, 1'b0);
            else chk("rx_rand_instr", app_instr, exp_instr.pop_front());
         end
      end
      chk("rx_queue_empty", exp_instr.size(), 0);
      chk("rx_idle", app_en, 1'b0);
      app_ack = 1'b0;

      // ---- RX ack: one pulse per process_iseq
      @(negedge clk); CHNL_RX = 1'b1;
      @(negedge clk); #1 chk("rx_ack_rise", CHNL_RX_ACK, 1'b1);
      acks = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         if (CHNL_RX_ACK) acks++;
      end
      chk("rx_ack_single", acks, 0);
      @(negedge clk); process_iseq = 1'b1;
      @(negedge clk); process_iseq = 1'b0;
      acks = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); #1;
         if (CHNL_RX_ACK) acks++;
      end
      chk("rx_ack_again", acks, 1);
      @(negedge clk); CHNL_RX = 1'b0; process_iseq = 1'b1;
      @(negedge clk); process_iseq = 1'b0;

      // ---- full TX transaction of 256 words
      for (int i = 0; i < 256; i++) push_word(rand_word());
      repeat (3) @(negedge clk);
      #1;
      chk("tx_start", CHNL_TX, 1'b1);
      chk("tx_start_valid", CHNL_TX_DATA_VALID, 1'b1);
      run_tx(4000, 1'b1);
      @(negedge clk);
      CHNL_TX_DATA_REN = 1'b1;
      #1;
      chk("tx_full_end", CHNL_TX, 1'b0);
      chk("tx_full_no_timeout", tx_timeout_cnt, 16'h0);

      // ---- stale REN: data pending but REN stays high
      for (int i = 0; i < 3; i++) push_word(rand_word());
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         chk("tx_stale_ren", CHNL_TX, 1'b0);
      end
      @(negedge clk); CHNL_TX_DATA_REN = 1'b0;
      @(negedge clk); #1;
      chk("tx_ren_low_start", CHNL_TX, 1'b1);
      chk("tx_ren_low_data", CHNL_TX_DATA, exp_beats[0]);

      // ---- timeout after 3 words
      run_tx(200, 1'b1);
      wait_drop(n);
      chk("tx_timeout_cycles", n, 128);
      chk("tx_timeout_cnt1", tx_timeout_cnt, 16'h1);

      // ---- reset in the middle of a word, with an RX word also held
      @(negedge clk);
      CHNL_TX_DATA_REN = 1'b0;
      CHNL_RX_DATA = {$urandom(), $urandom()}; CHNL_RX_DATA_VALID = 1'b1; app_ack = 1'b0;
      push_word(rand_word());
      push_word(rand_word());
      @(negedge clk);
      CHNL_RX_DATA_VALID = 1'b0;
      #1 chk("rx_held", app_en, 1'b1);
      @(negedge clk);
      @(negedge clk); #1;
      chk("tx_rst_seq_start", CHNL_TX, 1'b1);
      n = 0;
      for (int c = 0; c < 20 && n < 2; c++) begin
         @(negedge clk);
         CHNL_TX_DATA_REN = 1'b1;
         #1;
         if (CHNL_TX_DATA_VALID) begin
            chk("tx_pre_rst_data", CHNL_TX_DATA, exp_beats.pop_front());
            n++;
         end
      end
      chk("tx_pre_rst_beats", n, 2);
      @(negedge clk); #1;
      chk("tx_beat2_data", CHNL_TX_DATA, exp_beats[0]);
      rst = 1'b1;
      #1;
      chk("mid_rst_tx", CHNL_TX, 1'b0);
      chk("mid_rst_valid", CHNL_TX_DATA_VALID, 1'b0);
      chk("mid_rst_app_en", app_en, 1'b0);
      chk("mid_rst_rden", rdback_fifo_rden, 1'b0);
      chk("mid_rst_ack", CHNL_RX_ACK, 1'b0);
      chk("mid_rst_timeout_cnt", tx_timeout_cnt, 16'h0);
      void'(exp_beats.pop_front());
      void'(exp_beats.pop_front());
      CHNL_TX_DATA_REN = 1'b0;
      @(negedge clk); #1;
      chk("rst_hold_rden", rdback_fifo_rden, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("post_rst_tx", CHNL_TX, 1'b1);
      chk("post_rst_app_en", app_en, 1'b0);
      chk("post_rst_beat0", CHNL_TX_DATA, exp_beats[0]);
      run_tx(200, 1'b1);
      wait_drop(n);
      chk("post_rst_timeout_cycles", n, 128);
      chk("post_rst_timeout_cnt", tx_timeout_cnt, 16'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/softmc_riffa_bridge.md
# softmc_riffa_bridge

Parametrised RIFFA channel bridge between the PCIe host link and the SoftMC instruction/readback interfaces. It is the successor to the fixed-width PCIe app block. On RX it unpacks PCIe words of any supported width into 32-bit instructions. On TX it slices wide DRAM readback words into PCIe beats and groups them into length-configurable transactions, with an idle timeout and a timeout event counter.

## Interface
Parameters:
- C_PCI_DATA_WIDTH, 64: RIFFA data width; one of 32, 64 or 128.
- DQ_WIDTH, 64: DRAM DQ width. A readback word is DQ_WIDTH*4 bits and must be a multiple of C_PCI_DATA_WIDTH.
- CHUNKS_PER_TXN, 256: readback words per TX transaction.
- IDLE_TIMEOUT, 128: consecutive starved cycles before an open TX transaction is closed; must be ≥2.

Ports (derived: IPW = C_PCI_DATA_WIDTH/32, BEATS = DQ_WIDTH*4/C_PCI_DATA_WIDTH). One clock; reset is asynchronous and active-high.
- clk  in  1  sole clock; also driven out on CHNL_RX_CLK and CHNL_TX_CLK.
- rst  in  1  asynchronous, active-high reset.
- CHNL_RX_CLK / CHNL_TX_CLK  out  1  = clk.
- CHNL_RX, CHNL_RX_LAST  in  1  RIFFA RX request and last flag (LAST ignored).
- CHNL_RX_LEN  in  32, CHNL_RX_OFF  in  31  ignored.
- CHNL_RX_ACK  out  1  one-cycle acknowledge.
- CHNL_RX_DATA  in  C_PCI_DATA_WIDTH; CHNL_RX_DATA_VALID  in  1; CHNL_RX_DATA_REN  out  1.
- CHNL_TX  out  1; CHNL_TX_ACK  in  1 (ignored); CHNL_TX_LAST  out  1 (constant 1).
- CHNL_TX_LEN  out  32  constant CHUNKS_PER_TXN*DQ_WIDTH*4/32 (2048 at defaults).
- CHNL_TX_OFF  out  31  constant 0.
- CHNL_TX_DATA  out  C_PCI_DATA_WIDTH; CHNL_TX_DATA_VALID  out  1; CHNL_TX_DATA_REN  in  1.
- app_en  out  1; app_ack  in  1; app_instr  out  32  instruction stream to the MC.
- process_iseq  in  1  MC has started executing the received sequence.
- rdback_fifo_empty  in  1; rdback_fifo_rden  out  1; rdback_data  in  DQ_WIDTH*4  first-word-fall-through readback FIFO.
- tx_timeout_cnt  out  16  saturating count of TX transactions closed by timeout.

## Operation
- **RX ack FSM**, states RX_WAIT_REQ and RX_ACKED:
  - RX_WAIT_REQ: when CHNL_RX=1, pulse CHNL_RX_ACK for one cycle and go to RX_ACKED.
  - RX_ACKED: return to RX_WAIT_REQ when process_iseq=1.
- **RX unpacker**: holding register hold_data with hold_valid and index idx (0..IPW-1).
  - app_en = hold_valid; app_instr = hold_data[idx*32 +: 32]. The lowest slice is issued first.
  - CHNL_RX_DATA_REN = ~hold_valid | (app_ack & idx==IPW-1).
  - When REN=1: hold_valid <= CHNL_RX_DATA_VALID, hold_data <= CHNL_RX_DATA, idx <= 0.
  - Otherwise, on app_ack: idx <= idx+1.
- **Readback stage**: one-word register rd_data with rd_valid.
  - rdback_fifo_rden = ~rst & ~rdback_fifo_empty & (~rd_valid | consume).
  - A pop loads rd_data and sets rd_valid. A consume with no pop clears rd_valid.
- **TX FSM**, states TX_IDLE and TX_ACTIVE, with counters beat (0..BEATS-1), chunk (0..CHUNKS_PER_TXN-1) and idle_cnt:
  - TX_IDLE: CHNL_TX=0, VALID=0. Go to TX_ACTIVE when rd_valid & ~CHNL_TX_DATA_REN; clear beat, chunk and idle_cnt. The REN-low check guards against RIFFA holding REN high after a transaction ends.
  - TX_ACTIVE: CHNL_TX=1, CHNL_TX_DATA_VALID=rd_valid, CHNL_TX_DATA=rd_data[beat*C_PCI_DATA_WIDTH +: C_PCI_DATA_WIDTH].
  - On VALID&REN: idle_cnt<=0 and beat++. At beat==BEATS-1: beat<=0, consume=1, chunk++. If chunk==CHUNKS_PER_TXN-1 as well, go to TX_IDLE.
  - When rd_valid=0: idle_cnt++. At idle_cnt==IDLE_TIMEOUT-1, go to TX_IDLE and increment tx_timeout_cnt, saturating at 0xFFFF.
  - rd_valid cannot fall mid-word, so a timeout only ends a transaction at a word boundary.

## Timing
- Reset values: CHNL_RX_ACK=0, CHNL_TX=0, CHNL_TX_DATA_VALID=0, app_en=0, rdback_fifo_rden=0, tx_timeout_cnt=0. All FSMs go to their first state and all counters to 0.
- Reset mid-operation discards the held RX word and the held readback word immediately. No partial beat completes.
- RX latency: RX word accepted in cycle N → app_en=1 in cycle N+1. With app_ack held high, throughput is one instruction per cycle, bubble-free across words.
- CHNL_RX_ACK rises the cycle after CHNL_RX is sampled high. Only one ACK is issued per process_iseq.
- TX latency: FIFO pop in cycle N → data presented in cycle N+1 if in TX_ACTIVE. IDLE→ACTIVE is a one-cycle decision.
- A consume and a refill in the same cycle give back-to-back words with no bubble.
- Simultaneous final beat and timeout cannot occur, because the timeout requires rd_valid=0.

## Test plan
- **RX unpack**: defaults, send RX word 0x2222_2222_1111_1111 with app_ack=1 → app_instr 0x11111111 then 0x22222222 on consecutive cycles; REN=0 during the first.
- **RX ack**: CHNL_RX held high → exactly one ACK pulse; no second pulse until process_iseq pulses, then ACK fires again.
- **Full TX**: 256 readback words, REN=1 → CHNL_TX_LEN=2048, 1024 beats with slice order [63:0],[127:64],[191:128],[255:192], then TX_IDLE; tx_timeout_cnt=0.
- **Timeout**: 3 words then FIFO empty → CHNL_TX drops exactly 128 cycles after the last consumed beat; tx_timeout_cnt=1.
- **Stale REN**: REN held high after a transaction with data pending → no CHNL_TX until REN=0.
- **Reset mid-word**: assert rst during beat 2 → all outputs reach reset values immediately; after release, the next word starts from beat 0.
